// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: two OBI requesters sharing one OBI data-memory port.
// m0 = core LSU, m1 = secondary (fetch / debug / DMA).
// Ports: clk_i, rst_i (sync, active-high); per requester m{0,1}_req/gnt/addr/
// we/be/wdata/rvalid/rdata/err; memory side s_req/gnt/addr/we/be/wdata/
// rvalid/rdata/err.
// Macro OBI_ARB_RR_EN: defined = round-robin on conflict, else m0 has fixed
// priority. Responses are routed in order through an ID FIFO.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    input  logic                    s_err_i
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [MAX_OUTSTANDING-1:0] id_q;
    logic [PW-1:0]              wptr_q;
    logic [PW-1:0]              rptr_q;
    logic [CW-1:0]              cnt_q;
    logic                       lock_q;
    logic                       lock_id_q;

    logic full;
    logic empty;
    logic req;
    logic pick;
    logic sel;
    logic hs;
    logic pop;
    logic head;
    logic live;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef OBI_ARB_RR_EN
    // Last granted requester; resets to 1 so m0 wins the first conflict.
    logic last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= sel;
        end
    end

    assign pick = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
`else
    assign pick = m1_req_i & ~m0_req_i;
`endif

    assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);
    // A refused address phase stays locked onto the same requester.
    assign req   = ~full & (lock_q | m0_req_i | m1_req_i);
    assign sel   = lock_q ? lock_id_q : pick;
    assign hs    = req & s_gnt_i;
    assign pop   = s_rvalid_i & ~empty;
    assign head  = id_q[rptr_q];
    assign live  = ~rst_i;

    always_comb begin
        s_req_o     = 1'b0;
        s_addr_o    = '0;
        s_we_o      = 1'b0;
        s_be_o      = '0;
        s_wdata_o   = '0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m0_err_o    = 1'b0;
        m1_rvalid_o = 1'b0;
        m1_rdata_o  = '0;
        m1_err_o    = 1'b0;
        if (live) begin
            s_req_o = req;
            s_be_o  = {BW{1'b1}};
            if (req) begin
                s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
                s_we_o    = sel ? m1_we_i    : m0_we_i;
                s_be_o    = sel ? m1_be_i    : m0_be_i;
                s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
            end
            m0_gnt_o = hs & ~sel;
            m1_gnt_o = hs & sel;
            if (pop & ~head) begin
                m0_rvalid_o = 1'b1;
                m0_rdata_o  = s_rdata_i;
                m0_err_o    = s_err_i;
            end
            if (pop & head) begin
                m1_rvalid_o = 1'b1;
                m1_rdata_o  = s_rdata_i;
                m1_err_o    = s_err_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q      <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else begin
            if (hs) begin
                id_q[wptr_q] <= sel;
                wptr_q       <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({hs, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (hs) begin
                lock_q <= 1'b0;
            end else if (req) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && s_rvalid_i) begin
            assert (!empty)
            else $error("obi_mem_arbiter: rvalid with no outstanding id");
        end
    end
`endif

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed + randomized bench for obi_mem_arbiter.
// Reference model tracks outstanding ids in a queue and the held winner.
module tb_obi_mem_arbiter;

    localparam int MAXO = 2;
`ifdef OBI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        s_gnt, s_rvalid, s_err;
    logic [31:0] s_rdata;

    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic        m0_err_o, m1_err_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;

    always #5 clk = ~clk;

    obi_mem_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr),
        .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_wdata_i(m0_wdata),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m0_err_o(m0_err_o),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr),
        .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_wdata_i(m1_wdata),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt), .s_addr_o(s_addr_o),
        .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .s_err_i(s_err)
    );

    int checks = 0;
    int errors = 0;

    int out_q[$];
    int held = -1;
    int last = 1;
    bit e_req, e_hs, has;
    int e_sel, head;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        logic [31:0] ea, ewd;
        logic        ewe, ev0, ev1;
        logic [3:0]  ebe;
        #1;
        e_req = 0; e_hs = 0; e_sel = 0; has = 0; head = 0;
        ea = '0; ewd = '0; ewe = 1'b0; ebe = '0;
        if (!rst) begin
            e_req = (out_q.size() < MAXO) && (held >= 0 || m0_req || m1_req);
            if (held >= 0) e_sel = held;
            else if (m0_req && m1_req) e_sel = (RR && last == 0) ? 1 : 0;
            else e_sel = m1_req ? 1 : 0;
            e_hs = e_req && s_gnt;
            ebe = 4'hF;
            if (e_req) begin
                ea  = (e_sel == 1) ? m1_addr  : m0_addr;
                ewe = (e_sel == 1) ? m1_we    : m0_we;
                ebe = (e_sel == 1) ? m1_be    : m0_be;
                ewd = (e_sel == 1) ? m1_wdata : m0_wdata;
            end
            has = s_rvalid && out_q.size() > 0;
            if (has) head = out_q[0];
        end
        ev0 = has && head == 0;
        ev1 = has && head == 1;
        check("s_req",   64'(s_req_o),   64'(e_req));
        check("s_addr",  64'(s_addr_o),  64'(ea));
        check("s_we",    64'(s_we_o),    64'(ewe));
        check("s_be",    64'(s_be_o),    64'(ebe));
        check("s_wdata", 64'(s_wdata_o), 64'(ewd));
        check("m0_gnt",  64'(m0_gnt_o),  64'(e_hs && e_sel == 0));
        check("m1_gnt",  64'(m1_gnt_o),  64'(e_hs && e_sel == 1));
        check("m0_rv",   64'(m0_rvalid_o), 64'(ev0));
        check("m1_rv",   64'(m1_rvalid_o), 64'(ev1));
        check("m0_rd",   64'(m0_rdata_o),  64'(ev0 ? s_rdata : 32'h0));
        check("m1_rd",   64'(m1_rdata_o),  64'(ev1 ? s_rdata : 32'h0));
        check("m0_err",  64'(m0_err_o),    64'(ev0 && s_err));
        check("m1_err",  64'(m1_err_o),    64'(ev1 && s_err));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            out_q.delete();
            held = -1;
            last = 1;
        end else begin
            if (has) void'(out_q.pop_front());
            if (e_hs) begin
                out_q.push_back(e_sel);
                held = -1;
                last = e_sel;
            end else if (e_req) begin
                held = e_sel;
            end
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
        m0_be = 4'hF; m1_be = 4'hF;
        s_gnt = 0; s_rvalid = 0; s_err = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    bit g0, g1;

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        m0_req = 1; s_gnt = 1;
        settle();
        check("rst_req", 64'(s_req_o), 64'(0));
        check("rst_be", 64'(s_be_o), 64'(0));
        advance();
        do_reset();

        // single load
        m0_req = 1; m0_addr = 32'h100; s_gnt = 1;
        settle();
        check("ld_gnt0", 64'(m0_gnt_o), 64'(1));
        check("ld_gnt1", 64'(m1_gnt_o), 64'(0));
        advance();
        m0_req = 0; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        settle();
        check("ld_rv0", 64'(m0_rvalid_o), 64'(1));
        check("ld_rd0", 64'(m0_rdata_o), 64'(32'hDEADBEEF));
        check("ld_rv1", 64'(m1_rvalid_o), 64'(0));
        advance();

        // simultaneous requests
        do_reset();
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
        s_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            s_rvalid = (i > 0);
            s_rdata = 32'(i);
            settle();
            check("alt_gnt", 64'({m0_gnt_o, m1_gnt_o}),
                  64'((!RR || i % 2 == 0) ? 2'b10 : 2'b01));
            advance();
        end
        m0_req = 0; m1_req = 0; s_rvalid = 1;
        step();
        s_rvalid = 0;

        // locked address phase
        do_reset();
        m1_req = 1; m1_addr = 32'hA1;
        step();
        m0_req = 1; m0_addr = 32'hB0;
        settle();
        check("lk_addr1", 64'(s_addr_o), 64'(32'hA1));
        advance();
        step();
        s_gnt = 1;
        settle();
        check("lk_addr3", 64'(s_addr_o), 64'(32'hA1));
        check("lk_g1", 64'(m1_gnt_o), 64'(1));
        check("lk_g0", 64'(m0_gnt_o), 64'(0));
        advance();
        m1_req = 0;
        settle();
        check("lk_next", 64'(m0_gnt_o), 64'(1));
        advance();
        m0_req = 0; s_gnt = 0; s_rvalid = 1;
        step();
        step();
        s_rvalid = 0;

        // full
        do_reset();
        m0_req = 1; m0_addr = 32'h44; s_gnt = 1;
        step();
        step();
        s_rvalid = 1;
        settle();
        check("full_req", 64'(s_req_o), 64'(0));
        check("full_gnt", 64'(m0_gnt_o), 64'(0));
        advance();
        s_rvalid = 0;
        settle();
        check("unfull_gnt", 64'(m0_gnt_o), 64'(1));
        advance();
        m0_req = 0; s_rvalid = 1;
        step();
        step();
        s_rvalid = 0;

        // store with error
        do_reset();
        m0_req = 1; m0_we = 1; m0_be = 4'b0100;
        m0_wdata = 32'h00AB0000; m0_addr = 32'h200; s_gnt = 1;
        settle();
        check("st_we", 64'(s_we_o), 64'(1));
        check("st_be", 64'(s_be_o), 64'(4'b0100));
        check("st_wd", 64'(s_wdata_o), 64'(32'h00AB0000));
        advance();
        m0_req = 0; s_rvalid = 1; s_err = 1;
        settle();
        check("st_err0", 64'(m0_err_o), 64'(1));
        check("st_err1", 64'(m1_err_o), 64'(0));
        advance();

        // reset with two outstanding
        do_reset();
        m0_req = 1; s_gnt = 1;
        step();
        step();
        m0_req = 0; s_gnt = 0;
        rst = 1; s_rvalid = 1;
        settle();
        check("rs_rv0", 64'(m0_rvalid_o), 64'(0));
        advance();
        rst = 0; s_rvalid = 0; m1_req = 1; m1_addr = 32'h77; s_gnt = 1;
        settle();
        check("rs_req", 64'(s_req_o), 64'(1));
        check("rs_gnt1", 64'(m1_gnt_o), 64'(1));
        advance();
        m1_req = 0; s_rvalid = 1; s_rdata = 32'h1234;
        settle();
        check("rs_rv1", 64'(m1_rvalid_o), 64'(1));
        advance();
        idle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req && $urandom_range(0, 2) == 0) begin
                m0_req = 1; m0_addr = $urandom; m0_we = 1'($urandom);
                m0_be = 4'($urandom); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                m1_req = 1; m1_addr = $urandom; m1_we = 1'($urandom);
                m1_be = 4'($urandom); m1_wdata = $urandom;
            end
            s_gnt = ($urandom_range(0, 9) < 7);
            s_rvalid = (out_q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_rdata = $urandom;
            s_err = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            settle();
            g0 = e_hs && e_sel == 0;
            g1 = e_hs && e_sel == 1;
            advance();
            if (g0) m0_req = 0;
            if (g1) m1_req = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
